// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes and size helpers for the data-memory load/store unit
package lsu_pkg;

    localparam logic [2:0] FN3_LB  = 3'd0;
    localparam logic [2:0] FN3_LH  = 3'd1;
    localparam logic [2:0] FN3_LW  = 3'd2;
    localparam logic [2:0] FN3_LBU = 3'd4;
    localparam logic [2:0] FN3_LHU = 3'd5;
    localparam logic [2:0] FN3_SB  = 3'd0;
    localparam logic [2:0] FN3_SH  = 3'd1;
    localparam logic [2:0] FN3_SW  = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } lsu_state_e;

    typedef struct packed {
        logic [31:0] off;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  fn3;
        logic [1:0]  lane;
    } lsu_req_t;

    // byte-lane mask of an access before it is shifted into position
    function automatic logic [3:0] size_mask(input logic [2:0] fn3);
        return fn3[1:0] == 2'd0 ? 4'h1 : fn3[1:0] == 2'd1 ? 4'h3 : 4'hF;
    endfunction

    // access size in bytes
    function automatic logic [2:0] fn3_size(input logic [2:0] fn3);
        return fn3[1:0] == 2'd0 ? 3'd1 : fn3[1:0] == 2'd1 ? 3'd2 : 3'd4;
    endfunction

    function automatic logic fn3_legal(input logic we, input logic [2:0] fn3);
        return we ? (fn3 inside {FN3_SB, FN3_SH, FN3_SW})
                  : (fn3 inside {FN3_LB, FN3_LH, FN3_LW, FN3_LBU, FN3_LHU});
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response and data-memory beat signals of the load/store unit
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [2:0]  req_fn3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_addr, req_wdata, req_we, req_fn3,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_we, req_fn3,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables and lane-shifted store data for both beats, load extract and extend
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [2:0]  fn3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata0_i,
    input  logic [31:0] rdata1_i,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] ldata_o
);
    logic [7:0]  be_w;
    logic [63:0] wd_w;
    logic [31:0] ld;

    // shifting across a two-word window gives beat 0 in the low half and the spill-over beat in the high half
    assign be_w = {4'h0, size_mask(fn3_i)} << lane_i;
    assign {be1_o, be0_o} = be_w;
    assign wd_w = {32'h0, wdata_i} << {lane_i, 3'b000};
    assign {wdata1_o, wdata0_o} = wd_w;
    assign ld = 32'({rdata1_i, rdata0_i} >> {lane_i, 3'b000});

    // load extension: signed byte/half from bit 7/15, unsigned variants zero-filled
    always_comb begin
        ldata_o = fn3_i == FN3_LB  ? {{24{ld[7]}}, ld[7:0]} :
                  fn3_i == FN3_LH  ? {{16{ld[15]}}, ld[15:0]} :
                  fn3_i == FN3_LBU ? {24'h0, ld[7:0]} :
                  fn3_i == FN3_LHU ? {16'h0, ld[15:0]} : ld;
    end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: MEM-stage load/store initiator on a req/gnt + rvalid data-memory port.
// Define LSU_MISALIGNED_SPLIT_EN to split lane-crossing accesses into two word beats;
// without it such accesses respond with an error and no beat is issued.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_2000,
    parameter int unsigned MEM_BYTES = 16384,
    parameter int unsigned TIMEOUT   = 64
) (
    input logic    clk,
    input logic    rst,
    lsu_if.master  bus_io
);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    localparam logic [31:0] TMO       = 32'(TIMEOUT);

    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] acc_off;
    logic [2:0]  acc_size;
    logic        acc_err;
    logic        tmo;
    logic [31:0] beat_addr;
    logic [3:0]  be0, be1;
    logic [31:0] wdata0, wdata1, ldata;

    // offset is a plain 32-bit wrap so addresses below the base land far out of range
    assign acc_off  = bus_io.req_addr - BASE_ADDR;
    assign acc_size = fn3_size(bus_io.req_fn3);

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic split;
    assign split   = |be1;
    assign acc_err = (({1'b0, acc_off} + 33'(acc_size)) > MEM_LIMIT)
                   || !fn3_legal(bus_io.req_we, bus_io.req_fn3);
`else
    assign acc_err = (({1'b0, acc_off} + 33'(acc_size)) > MEM_LIMIT)
                   || !fn3_legal(bus_io.req_we, bus_io.req_fn3)
                   || ((3'(acc_off[1:0]) + acc_size) > 3'd4);
`endif

    // counter holds the cycles already spent in the current REQx/WAITx state
    assign tmo = (TMO != 32'd0) && (cnt_q + 32'd1 == TMO);

    lsu_lane_align u_align (
        .lane_i   (req_q.lane),
        .fn3_i    (req_q.fn3),
        .wdata_i  (req_q.wdata),
        .rdata0_i (rdata0_q),
        .rdata1_i (rdata1_q),
        .be0_o    (be0),
        .be1_o    (be1),
        .wdata0_o (wdata0),
        .wdata1_o (wdata1),
        .ldata_o  (ldata)
    );

    // next state: accept, beat handshakes, per-state timeout; gnt wins over a same-cycle rvalid
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err_d    = err_q;
        cnt_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (bus_io.req_valid) begin
                    req_d    = '{off: acc_off, wdata: bus_io.req_wdata, we: bus_io.req_we,
                                 fn3: bus_io.req_fn3, lane: acc_off[1:0]};
                    err_d    = acc_err;
                    rdata0_d = '0;
                    rdata1_d = '0;
                    state_d  = acc_err ? S_RESP : S_REQ0;
                end
            end
            S_REQ0: begin
                if (bus_io.mem_gnt) state_d = S_WAIT0;
                else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else cnt_d = cnt_q + 32'd1;
            end
            S_WAIT0: begin
                if (bus_io.mem_rvalid) begin
                    rdata0_d = bus_io.mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_d  = split ? S_REQ1 : S_RESP;
`else
                    state_d  = S_RESP;
`endif
                end else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else cnt_d = cnt_q + 32'd1;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_REQ1: begin
                if (bus_io.mem_gnt) state_d = S_WAIT1;
                else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else cnt_d = cnt_q + 32'd1;
            end
            S_WAIT1: begin
                if (bus_io.mem_rvalid) begin
                    rdata1_d = bus_io.mem_rdata;
                    state_d  = S_RESP;
                end else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else cnt_d = cnt_q + 32'd1;
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // registered state; reset abandons any in-flight beat without a response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign beat_addr         = {req_q.off[31:2], 2'b00};
    assign bus_io.req_ready  = state_q == S_IDLE;
    assign bus_io.resp_valid = state_q == S_RESP;
    assign bus_io.resp_err   = bus_io.resp_valid && err_q;
    assign bus_io.resp_rdata = (bus_io.resp_valid && !err_q && !req_q.we) ? ldata : '0;
    assign bus_io.mem_req    = state_q == S_REQ0 || state_q == S_REQ1;
    assign bus_io.mem_we     = bus_io.mem_req && req_q.we;
    assign bus_io.mem_addr   = state_q == S_REQ0 ? beat_addr :
                               state_q == S_REQ1 ? beat_addr + 32'd4 : '0;
    assign bus_io.mem_be     = state_q == S_REQ0 ? be0 : state_q == S_REQ1 ? be1 : '0;
    assign bus_io.mem_wdata  = state_q == S_REQ0 ? wdata0 : state_q == S_REQ1 ? wdata1 : '0;
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed table, hand sequences and random accesses against a byte-level memory model
module tb_lsu_mem_master;
    localparam logic [31:0] BASE = 32'h8000_2000;
    localparam int MB = 16384;
    localparam int TO = 64;
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if bus();

    lsu_mem_master #(.BASE_ADDR(BASE), .MEM_BYTES(MB), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] dmem [MB/4];
    logic [7:0]  rmem [MB];

    int          nb, lat, reqcyc;
    bit          got;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] b_addr [2];
    logic [3:0]  b_be [2];
    logic [31:0] b_wd [2];
    logic        b_we [2];

    logic        e_err;
    int          e_nb;
    logic [31:0] e_addr [2];
    logic [3:0]  e_be [2];
    logic [31:0] e_wd [2];
    logic [31:0] e_rd;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  fn3;
        logic        err;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rd;
    } vec_t;

    vec_t tv [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic init_mem();
        logic [31:0] w;
        for (int i = 0; i < MB/4; i++) begin
            w = $urandom;
            dmem[i] = w;
            for (int k = 0; k < 4; k++) rmem[4*i+k] = w[8*k +: 8];
        end
    endtask

    // one request, with the bench acting as memory: gnt after gdly request cycles, rvalid rdly cycles after gnt
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                          input logic [2:0] fn3, input int gdly, input int rdly);
        int pend, gc, cyc;
        logic [31:0] pa;
        pend = -1; gc = 0; cyc = 0; pa = '0;
        nb = 0; reqcyc = 0; got = 0; r_rdata = '0; r_err = 1'b0; lat = 0;
        @(negedge clk);
        chk("req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_we    = we;
        bus.req_fn3   = fn3;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.req_valid  = 1'b0;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (bus.resp_valid) begin
                got = 1; lat = cyc; r_rdata = bus.resp_rdata; r_err = bus.resp_err;
            end else begin
                if (pend == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = dmem[pa[13:2]];
                    pend = -1;
                end else if (pend > 0) pend--;
                if (bus.mem_req) begin
                    reqcyc++;
                    if (gc == gdly) begin
                        if (nb < 2) begin
                            b_addr[nb] = bus.mem_addr; b_be[nb] = bus.mem_be;
                            b_wd[nb] = bus.mem_wdata; b_we[nb] = bus.mem_we;
                        end
                        pa = bus.mem_addr;
                        if (bus.mem_we)
                            for (int k = 0; k < 4; k++)
                                if (bus.mem_be[k]) dmem[pa[13:2]][8*k +: 8] = bus.mem_wdata[8*k +: 8];
                        bus.mem_gnt = 1'b1;
                        pend = rdly; gc = 0; nb++;
                    end else gc++;
                end
            end
        end
        chk("resp_seen", 32'(got), 1);
        @(negedge clk);
        chk("resp_pulse", bus.resp_valid, 0);
    endtask

    // expected outcome built byte by byte from the addressing rules; updates the reference memory on stores
    task automatic model(input logic [31:0] addr, input logic [31:0] wdata, input logic we, input logic [2:0] fn3);
        logic [31:0] off, a;
        int size, bt;
        bit legal, mis;
        off   = addr - BASE;
        size  = fn3[1:0] == 2'd0 ? 1 : fn3[1:0] == 2'd1 ? 2 : 4;
        legal = we ? (fn3 <= 3'd2) : (fn3 != 3'd3 && fn3 != 3'd6 && fn3 != 3'd7);
        mis   = (off % 4) + size > 4;
        e_err = !legal || (64'(off) + 64'(size) > 64'(MB)) || (mis && !SPLIT);
        e_nb  = e_err ? 0 : mis ? 2 : 1;
        e_addr[0] = off & ~32'd3;
        e_addr[1] = e_addr[0] + 32'd4;
        e_be = '{4'h0, 4'h0};
        e_wd = '{32'h0, 32'h0};
        e_rd = '0;
        if (!e_err) begin
            for (int k = 0; k < size; k++) begin
                a  = off + 32'(k);
                bt = int'((a >> 2) - (off >> 2));
                e_be[bt][a % 4] = 1'b1;
                e_wd[bt][8*(a % 4) +: 8] = wdata[8*k +: 8];
                if (we) rmem[a] = wdata[8*k +: 8];
                else e_rd[8*k +: 8] = rmem[a];
            end
            if (!we && fn3 == 3'd0 && e_rd[7]) e_rd = e_rd | 32'hFFFF_FF00;
            if (!we && fn3 == 3'd1 && e_rd[15]) e_rd = e_rd | 32'hFFFF_0000;
        end
    endtask

    initial begin
        logic [31:0] ra, rw;
        logic rwe;
        logic [2:0] rfn;
        int sel;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_we = 1'b0; bus.req_fn3 = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_be", bus.mem_be, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        rst = 1'b0;

        init_mem();
        dmem[4]     = 32'hDEAD_BEEF;
        dmem[0]     = 32'h8012_3456;
        dmem[1]     = 32'h1234_5678;
        dmem[12'hFFF] = 32'h0BAD_F00D;

        tv[0]  = '{32'h8000_2010, 32'h0, 1'b0, 3'd2, 1'b0, 1, 32'h10, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF};
        tv[1]  = '{32'h8000_2003, 32'h0, 1'b0, 3'd0, 1'b0, 1, 32'h0, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF_FF80};
        tv[2]  = '{32'h8000_2003, 32'h0, 1'b0, 3'd4, 1'b0, 1, 32'h0, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_0080};
        tv[3]  = '{32'h8000_2002, 32'h0, 1'b0, 3'd1, 1'b0, 1, 32'h0, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF_8012};
        tv[4]  = '{32'h8000_2002, 32'h0, 1'b0, 3'd5, 1'b0, 1, 32'h0, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000_8012};
        tv[5]  = '{32'h8000_2001, 32'h5566_77AB, 1'b1, 3'd0, 1'b0, 1, 32'h0, 4'h2, 32'h0000_AB00, 32'h0, 4'h0, 32'h0, 32'h0};
`ifdef LSU_MISALIGNED_SPLIT_EN
        tv[6]  = '{32'h8000_2006, 32'h0, 1'b0, 3'd2, 1'b0, 2, 32'h4, 4'hC, 32'h0, 32'h8, 4'h3, 32'h0, 32'h0};
        tv[7]  = '{32'h8000_2006, 32'h1122_3344, 1'b1, 3'd2, 1'b0, 2, 32'h4, 4'hC, 32'h3344_0000, 32'h8, 4'h3, 32'h0000_1122, 32'h0};
        tv[6].a0 = 32'h0; tv[6].a1 = 32'h4;
        tv[6].addr = 32'h8000_2002; tv[6].rd = 32'h5678_8012;
`else
        tv[6]  = '{32'h8000_2002, 32'h0, 1'b0, 3'd2, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
        tv[7]  = '{32'h8000_2006, 32'h1122_3344, 1'b1, 3'd2, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
`endif
        tv[8]  = '{32'h8000_1FFC, 32'h0, 1'b0, 3'd2, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
        tv[9]  = '{32'h8000_6000, 32'h0, 1'b0, 3'd2, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
        tv[10] = '{32'h8000_2010, 32'h0, 1'b0, 3'd3, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
        tv[11] = '{32'h8000_2010, 32'h0, 1'b1, 3'd4, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
        tv[12] = '{32'h8000_5FFC, 32'h0, 1'b0, 3'd2, 1'b0, 1, 32'h3FFC, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D};
        tv[13] = '{32'h8000_5FFE, 32'h0000_BEEF, 1'b1, 3'd1, 1'b0, 1, 32'h3FFC, 4'hC, 32'hBEEF_0000, 32'h0, 4'h0, 32'h0, 32'h0};
        tv[14] = '{32'h8000_5FFF, 32'h0000_BEEF, 1'b1, 3'd1, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
        tv[15] = '{32'h8000_1FFF, 32'h0, 1'b0, 3'd0, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            access(tv[i].addr, tv[i].wdata, tv[i].we, tv[i].fn3, 0, 0);
            chk($sformatf("tv%0d_err", i), r_err, tv[i].err);
            chk($sformatf("tv%0d_beats", i), nb, tv[i].nb);
            chk($sformatf("tv%0d_lat", i), lat, tv[i].err ? 1 : tv[i].nb == 2 ? 5 : 3);
            chk($sformatf("tv%0d_rdata", i), r_rdata, tv[i].rd);
            if (tv[i].nb >= 1) begin
                chk($sformatf("tv%0d_addr0", i), b_addr[0], tv[i].a0);
                chk($sformatf("tv%0d_be0", i), b_be[0], tv[i].be0);
                chk($sformatf("tv%0d_we0", i), b_we[0], tv[i].we);
                if (tv[i].we) chk($sformatf("tv%0d_wd0", i), b_wd[0] & bmask(tv[i].be0), tv[i].wd0);
            end
            if (tv[i].nb == 2) begin
                chk($sformatf("tv%0d_addr1", i), b_addr[1], tv[i].a1);
                chk($sformatf("tv%0d_be1", i), b_be[1], tv[i].be1);
                if (tv[i].we) chk($sformatf("tv%0d_wd1", i), b_wd[1] & bmask(tv[i].be1), tv[i].wd1);
            end
        end

        access(32'h8000_2010, 32'h0, 1'b0, 3'd2, 1000, 0);
        chk("gnt_tmo_err", r_err, 1);
        chk("gnt_tmo_req_cycles", reqcyc, TO);
        chk("gnt_tmo_lat", lat, TO + 1);
        chk("gnt_tmo_rdata", r_rdata, 0);
        access(32'h8000_2010, 32'h0, 1'b0, 3'd2, 0, 1000);
        chk("rv_tmo_err", r_err, 1);
        chk("rv_tmo_lat", lat, TO + 2);
        access(32'h8000_2010, 32'h0, 1'b0, 3'd2, 0, 0);
        chk("after_tmo_err", r_err, 0);
        chk("after_tmo_rdata", r_rdata, 32'hDEAD_BEEF);

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h8000_2010; bus.req_we = 1'b0; bus.req_fn3 = 3'd2;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mid_rst_req0", bus.mem_req, 1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("mid_rst_wait0", bus.mem_req, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", bus.req_ready, 1);
        chk("mid_rst_mem_req", bus.mem_req, 0);
        chk("mid_rst_resp", bus.resp_valid, 0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_rvalid_resp", bus.resp_valid, 0);
            @(negedge clk);
        end
        access(32'h8000_2010, 32'h0, 1'b0, 3'd2, 0, 0);
        chk("after_rst_rdata", r_rdata, 32'hDEAD_BEEF);

        init_mem();
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            ra  = sel == 0 ? BASE - 32'($urandom_range(1, 8)) :
                  sel == 1 ? BASE + 32'(MB) - 32'($urandom_range(0, 6)) :
                  BASE + 32'($urandom_range(0, MB - 1));
            rw  = $urandom;
            rwe = 1'($urandom_range(0, 1));
            rfn = 3'($urandom_range(0, 7));
            model(ra, rw, rwe, rfn);
            access(ra, rw, rwe, rfn, $urandom_range(0, 3), $urandom_range(0, 3));
            chk($sformatf("rnd%0d_err", i), r_err, e_err);
            chk($sformatf("rnd%0d_beats", i), nb, e_nb);
            chk($sformatf("rnd%0d_rdata", i), r_rdata, e_rd);
            for (int b = 0; b < e_nb; b++) begin
                chk($sformatf("rnd%0d_addr%0d", i, b), b_addr[b], e_addr[b]);
                chk($sformatf("rnd%0d_be%0d", i, b), b_be[b], e_be[b]);
                chk($sformatf("rnd%0d_we%0d", i, b), b_we[b], rwe);
                if (rwe) chk($sformatf("rnd%0d_wd%0d", i, b), b_wd[b] & bmask(e_be[b]), e_wd[b]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
